// File: rtl/bias_load_ctrl.sv
// bias_load_ctrl: accepts a (layer, count) load command, then turns a stream of
// bias words into addressed one-cycle write strobes to the per-neuron bias bank.
// Zero-length commands complete at once, and oversize commands are rejected.
// Neither kind of command issues any writes.

module bias_load_ctrl #(
    parameter int DATA_W      = 32,
    parameter int LAYER_W     = 8,
    parameter int MAX_NEURONS = 64,
    parameter int NEURON_W    = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LAYER_W-1:0]  cmd_layer,
    input  logic [NEURON_W-1:0] cmd_count,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    output logic                bias_wr_en,
    output logic [LAYER_W-1:0]  bias_wr_layer,
    output logic [NEURON_W-1:0] bias_wr_neuron,
    output logic [DATA_W-1:0]   bias_wr_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [NEURON_W-1:0] MAX_COUNT = NEURON_W'(MAX_NEURONS);
    localparam logic [NEURON_W-1:0] ONE       = NEURON_W'(1);

    state_t              state;
    logic [LAYER_W-1:0]  layer_q;
    logic [NEURON_W-1:0] count_q;
    logic [NEURON_W-1:0] idx;

    // Handshake readiness and busy are pure decodes of the state register.
    // This keeps them glitch-free and avoids any combinational path from
    // the inputs.
    assign cmd_ready = (state == IDLE);
    assign s_ready   = (state == LOAD);
    assign busy      = (state == LOAD);

    // Command sequencer: accept or reject commands, then step through the bias words.
    // NOTE: all state here uses non-blocking assignment so every register samples
    // pre-edge values; blocking would let idx/state updates leak into later lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            layer_q        <= '0;
            count_q        <= '0;
            idx            <= '0;
            bias_wr_en     <= 1'b0;
            bias_wr_layer  <= '0;
            bias_wr_neuron <= '0;
            bias_wr_data   <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            // Strobes default low; address/data registers hold their last write.
            bias_wr_en <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_count == '0) begin
                            done <= 1'b1;
                        end else if (cmd_count > MAX_COUNT) begin
                            err <= 1'b1;
                        end else begin
                            layer_q <= cmd_layer;
                            count_q <= cmd_count;
                            idx     <= '0;
                            state   <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (s_valid) begin
                        bias_wr_en     <= 1'b1;
                        bias_wr_layer  <= layer_q;
                        bias_wr_neuron <= idx;
                        bias_wr_data   <= s_data;
                        idx            <= idx + ONE;
                        // Final word: done coincides with the last write strobe.
                        if (idx == count_q - ONE) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
